// File: rtl/axi4_lite_regbank_if.sv
// AXI4-Lite slave port bundle for axi4_lite_regbank: AW/W/B write channels and AR/R read channels.
interface axi4_lite_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AW_ADDR;
  logic                    AW_VALID;
  logic                    AW_READY;
  logic [DATA_WIDTH-1:0]   W_DATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    W_VALID;
  logic                    W_READY;
  logic [1:0]              B_RESP;
  logic                    B_VALID;
  logic                    B_READY;
  logic [ADDR_WIDTH-1:0]   AR_ADDR;
  logic                    AR_VALID;
  logic                    AR_READY;
  logic [DATA_WIDTH-1:0]   R_DATA;
  logic [1:0]              R_RESP;
  logic                    R_VALID;
  logic                    R_READY;

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, WSTRB, W_VALID, B_READY, AR_ADDR, AR_VALID, R_READY,
    input  AW_READY, W_READY, B_RESP, B_VALID, AR_READY, R_DATA, R_RESP, R_VALID
  );

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, WSTRB, W_VALID, B_READY, AR_ADDR, AR_VALID, R_READY,
    output AW_READY, W_READY, B_RESP, B_VALID, AR_READY, R_DATA, R_RESP, R_VALID
  );
endinterface

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite register bank with independent AW/W acceptance, byte strobes and SLVERR on out-of-range.
// Define AXI4_LITE_REGBANK_RO_ID_EN to make the last register a read-only ID register.
module axi4_lite_regbank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  // "A4L1" is not a hex literal; A411 stands in for it
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'h0000_A411)
) (
  input  logic                           clk,
  input  logic                           resetn,
  axi4_lite_regbank_if.slave             s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS * NB);
  localparam logic [IDXW-1:0]     LAST  = IDXW'(NUM_REGS - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4_LITE_REGBANK_RO_ID_EN
  localparam bit RO_ID = 1'b1;
`else
  localparam bit RO_ID = 1'b0;
`endif

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;

  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [NB-1:0]         r_w_strb;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [1:0]            r_b_resp;
  logic [1:0]            r_r_resp;
  logic [DATA_WIDTH-1:0] r_r_data;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [NB-1:0]         w_wr_strb;
  logic [IDXW-1:0]       w_wr_idx, w_rd_idx;
  logic                  w_wr_in_range, w_wr_ok, w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_rd_val;

  // READY signals are pure state decodes
  assign s_axi.AW_READY = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_W);
  assign s_axi.W_READY  = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_AW);
  assign s_axi.AR_READY = (r_rd_state == RD_IDLE);
  assign s_axi.B_VALID  = (r_wr_state == WR_RESP);
  assign s_axi.R_VALID  = (r_rd_state == RD_RESP);
  assign s_axi.B_RESP   = r_b_resp;
  assign s_axi.R_RESP   = r_r_resp;
  assign s_axi.R_DATA   = r_r_data;

  assign w_aw_hs = s_axi.AW_VALID && s_axi.AW_READY;
  assign w_w_hs  = s_axi.W_VALID  && s_axi.W_READY;
  assign w_ar_hs = s_axi.AR_VALID && s_axi.AR_READY;

  // Whichever half arrived earlier comes from its holding register
  assign w_wr_addr = (r_wr_state == WR_HAVE_AW) ? r_aw_addr : s_axi.AW_ADDR;
  assign w_wr_data = (r_wr_state == WR_HAVE_W)  ? r_w_data  : s_axi.W_DATA;
  assign w_wr_strb = (r_wr_state == WR_HAVE_W)  ? r_w_strb  : s_axi.WSTRB;

  assign w_wr_idx      = w_wr_addr[LSB +: IDXW];
  assign w_wr_in_range = ({1'b0, w_wr_addr} < LIMIT);
  assign w_wr_ok       = w_wr_in_range && !(RO_ID && (w_wr_idx == LAST));

  assign w_rd_idx      = s_axi.AR_ADDR[LSB +: IDXW];
  assign w_rd_in_range = ({1'b0, s_axi.AR_ADDR} < LIMIT);

  always_comb begin
    w_rd_val = '0;
    if (w_rd_in_range) begin
      if (RO_ID && (w_rd_idx == LAST)) w_rd_val = ID_VALUE;
      else                             w_rd_val = r_regs[w_rd_idx];
    end
  end

  always_comb begin
    w_wr_next = r_wr_state;
    w_commit  = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end else if (w_aw_hs) begin
          w_wr_next = WR_HAVE_AW;
        end else if (w_w_hs) begin
          w_wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_w_hs) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        if (w_aw_hs) begin
          w_commit  = 1'b1;
          w_wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.B_READY) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (s_axi.AR_VALID) w_rd_next = RD_RESP;
      RD_RESP: if (s_axi.R_READY)  w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
      r_rd_state <= w_rd_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) r_aw_addr <= s_axi.AW_ADDR;
      if (w_w_hs) begin
        r_w_data <= s_axi.W_DATA;
        r_w_strb <= s_axi.WSTRB;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (w_wr_strb[b]) r_regs[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
      end
    end
  end

  // Read data samples pre-commit contents, so a same-edge write is not visible
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_b_resp <= RESP_OKAY;
      r_r_resp <= RESP_OKAY;
      r_r_data <= '0;
    end else begin
      if (w_commit) r_b_resp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_r_data <= w_rd_val;
        r_r_resp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regq
    if (RO_ID && (gi == NUM_REGS - 1)) begin : g_id
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
    end else begin : g_rw
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  end

endmodule
